// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  // Address width for a given depth, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports and scrub control.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
);
  localparam int AW = clog2_min1(DEPTH);

  logic [NWRITE-1:0]       we;
  logic [NWRITE*AW-1:0]    wa;
  logic [NWRITE*WIDTH-1:0] wd;
  logic [NREAD*AW-1:0]     ra;
  logic [NREAD*WIDTH-1:0]  rd;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;

  modport master (
    output we, wa, wd, ra, clr_req,
    input  rd, clr_busy, clr_done
  );

  modport slave (
    input  we, wa, wd, ra, clr_req,
    output rd, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Sequential scrub engine: walks ptr from 0 to DEPTH-1 writing zeros.
//
// state | meaning
// IDLE  | array available to user ports, waiting for clr_req
// CLEAR | zeroing entry ptr each edge, user access blocked
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          done_q, done_d;

  // State register; reset parks the engine at the start of a fresh scrub.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept a request only in IDLE, finish after entry DEPTH-1.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs: busy and the array write strobe follow the CLEAR state directly.
  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_we   = (state_q == CLEAR);
    clr_addr = ptr_q;
    clr_done = done_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero entry,
// optional write-first bypass and a built-in scrub engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam int AW = clog2_min1(DEPTH);

  logic                   clr_busy;
  logic                   clr_we;
  logic [AW-1:0]          clr_addr;
  logic [NWRITE-1:0]      wv;
  logic [NREAD*WIDTH-1:0] rd_c;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];

  // Address is backed by a writable/readable entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_clr_fsm #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_clr (
    .clk     (clk),
    .reset   (reset),
    .clr_req (bus.clr_req),
    .clr_busy(clr_busy),
    .clr_done(bus.clr_done),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign bus.clr_busy = clr_busy;
  assign bus.rd       = rd_c;

  // Per-port effective write enable: blocked while scrubbing, dropped if invalid.
  always_comb begin
    wv = '0;
    for (int i = 0; i < NWRITE; i++) begin
      wv[i] = bus.we[i] && !clr_busy && addr_ok(bus.wa[i*AW +: AW]);
    end
  end

  // Array next value: scrub has priority; otherwise later ports overwrite earlier.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (clr_we) begin
        if (clr_addr == AW'(k)) mem_d[k] = '0;
      end else begin
        for (int i = 0; i < NWRITE; i++) begin
          if (wv[i] && (bus.wa[i*AW +: AW] == AW'(k))) mem_d[k] = bus.wd[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Storage has no reset; contents are only changed by the scrub or user writes.
  always_ff @(posedge clk) begin
    if (!reset) mem_q <= mem_d;
  end

  // Read ports: zero when busy or invalid, else stored value, optionally bypassed.
  always_comb begin
    rd_c = '0;
    for (int j = 0; j < NREAD; j++) begin
      if (!clr_busy && addr_ok(bus.ra[j*AW +: AW])) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (bus.ra[j*AW +: AW] == AW'(k)) rd_c[j*WIDTH +: WIDTH] = mem_q[k];
        end
        if (BYPASS != 0) begin
          for (int i = 0; i < NWRITE; i++) begin
            if (wv[i] && (bus.wa[i*AW +: AW] == bus.ra[j*AW +: AW])) begin
              rd_c[j*WIDTH +: WIDTH] = bus.wd[i*WIDTH +: WIDTH];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations driven side by side against an
// array-based reference model.
module tb_regfile_mp;

  localparam int W   = 32;
  localparam int DA  = 32;
  localparam int NRA = 2;
  localparam int NWA = 2;
  localparam int AWA = 5;
  localparam int DB  = 24;
  localparam int NRB = 2;
  localparam int NWB = 1;
  localparam int AWB = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(W), .DEPTH(DA), .NREAD(NRA), .NWRITE(NWA)) bus_a ();
  regfile_mp_if #(.WIDTH(W), .DEPTH(DB), .NREAD(NRB), .NWRITE(NWB)) bus_b ();

  regfile_mp #(.WIDTH(W), .DEPTH(DA), .NREAD(NRA), .NWRITE(NWA), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  regfile_mp #(.WIDTH(W), .DEPTH(DB), .NREAD(NRB), .NWRITE(NWB), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: entry contents, remaining scrub cycles, expected done pulse.
  logic [W-1:0] mod_a [DA];
  logic [W-1:0] mod_b [DB];
  int sl_a = DA;
  int sl_b = DB;
  bit dn_a = 1'b0;
  bit dn_b = 1'b0;

  function automatic logic [W-1:0] ref_a(int j);
    int ra;
    logic [W-1:0] v;
    ra = int'(bus_a.ra[j*AWA +: AWA]);
    if (sl_a > 0 || ra >= DA || ra == 0) return '0;
    v = mod_a[ra];
    for (int i = 0; i < NWA; i++)
      if (bus_a.we[i] && int'(bus_a.wa[i*AWA +: AWA]) == ra) v = bus_a.wd[i*W +: W];
    return v;
  endfunction

  function automatic logic [W-1:0] ref_b(int j);
    int ra;
    ra = int'(bus_b.ra[j*AWB +: AWB]);
    if (sl_b > 0 || ra >= DB || ra == 0) return '0;
    return mod_b[ra];
  endfunction

  // Advance the model by one edge using the inputs now applied, then step past the edge.
  task automatic tick();
    if (reset) begin
      sl_a = DA; sl_b = DB; dn_a = 1'b0; dn_b = 1'b0;
    end else begin
      dn_a = 1'b0;
      if (sl_a > 0) begin
        mod_a[DA - sl_a] = '0;
        sl_a--;
        dn_a = (sl_a == 0);
      end else begin
        for (int i = 0; i < NWA; i++) begin
          int a;
          a = int'(bus_a.wa[i*AWA +: AWA]);
          if (bus_a.we[i] && a < DA && a != 0) mod_a[a] = bus_a.wd[i*W +: W];
        end
        if (bus_a.clr_req) sl_a = DA;
      end
      dn_b = 1'b0;
      if (sl_b > 0) begin
        mod_b[DB - sl_b] = '0;
        sl_b--;
        dn_b = (sl_b == 0);
      end else begin
        for (int i = 0; i < NWB; i++) begin
          int a;
          a = int'(bus_b.wa[i*AWB +: AWB]);
          if (bus_b.we[i] && a < DB && a != 0) mod_b[a] = bus_b.wd[i*W +: W];
        end
        if (bus_b.clr_req) sl_b = DB;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Measures busy length and done position over 40 cycles; call at a negedge.
  task automatic count_scrub(output int ba, output int da, output int dat,
                             output int bb, output int db, output int dbt);
    ba = 0; da = 0; dat = 0; bb = 0; db = 0; dbt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus_a.clr_busy === 1'b1) ba++;
      if (bus_a.clr_done === 1'b1) begin da++; if (dat == 0) dat = c; end
      if (bus_b.clr_busy === 1'b1) bb++;
      if (bus_b.clr_done === 1'b1) begin db++; if (dbt == 0) dbt = c; end
      tick();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int ba, da, dat, bb, db, dbt;
    bus_a.ra = {5'd6, 5'd5};
    bus_b.ra = {5'd6, 5'd5};
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (bus_a.clr_busy !== 1'b1 || bus_a.clr_done !== 1'b0 || bus_a.rd !== '0) begin
      n_err++;
      $display("FAIL reset_a: busy=%b done=%b rd=%h, want busy=1 done=0 rd=0",
               bus_a.clr_busy, bus_a.clr_done, bus_a.rd);
    end
    n_vec++;
    if (bus_b.clr_busy !== 1'b1 || bus_b.clr_done !== 1'b0 || bus_b.rd !== '0) begin
      n_err++;
      $display("FAIL reset_b: busy=%b done=%b rd=%h, want busy=1 done=0 rd=0",
               bus_b.clr_busy, bus_b.clr_done, bus_b.rd);
    end
    reset = 1'b0;
    count_scrub(ba, da, dat, bb, db, dbt);
    n_vec++;
    if (ba != DA || da != 1 || dat != DA + 1) begin
      n_err++;
      $display("FAIL reset_scrub_a: busy=%0d done=%0d at=%0d, want %0d 1 %0d", ba, da, dat, DA, DA + 1);
    end
    n_vec++;
    if (bb != DB || db != 1 || dbt != DB + 1) begin
      n_err++;
      $display("FAIL reset_scrub_b: busy=%0d done=%0d at=%0d, want %0d 1 %0d", bb, db, dbt, DB, DB + 1);
    end
    #1;
    n_vec++;
    if (bus_a.rd[W-1:0] !== 32'h0 || bus_b.rd[W-1:0] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_read5: a=%h b=%h, want 0", bus_a.rd[W-1:0], bus_b.rd[W-1:0]);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus_b.we = 1'b1; bus_b.wa = 5'd7; bus_b.wd = 32'hDEADBEEF; bus_b.ra = {5'd0, 5'd7};
    #1;
    n_vec++;
    if (bus_b.rd[W-1:0] !== ref_b(0) || bus_b.rd[W-1:0] !== 32'h0) begin
      n_err++;
      $display("FAIL basic_old: rd0=%h, want %h", bus_b.rd[W-1:0], ref_b(0));
    end
    tick();
    bus_b.we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_b.rd[W-1:0] !== 32'hDEADBEEF || bus_b.rd[2*W-1:W] !== 32'h0) begin
      n_err++;
      $display("FAIL basic_new: rd0=%h rd1=%h, want deadbeef 0", bus_b.rd[W-1:0], bus_b.rd[2*W-1:W]);
    end
    bus_b.we = 1'b1; bus_b.wa = 5'd0; bus_b.wd = 32'h1234; bus_b.ra = {5'd0, 5'd0};
    tick();
    bus_b.we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_b.rd !== '0) begin
      n_err++;
      $display("FAIL basic_zero: rd=%h, want 0", bus_b.rd);
    end
    bus_b.we = 1'b1; bus_b.wa = 5'd30; bus_b.wd = 32'hAA; bus_b.ra = {5'd0, 5'd30};
    #1;
    n_vec++;
    if (bus_b.rd[W-1:0] !== 32'h0) begin
      n_err++;
      $display("FAIL oor_during: rd0=%h, want 0", bus_b.rd[W-1:0]);
    end
    tick();
    bus_b.we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_b.rd[W-1:0] !== 32'h0) begin
      n_err++;
      $display("FAIL oor_after: rd0=%h, want 0", bus_b.rd[W-1:0]);
    end
    for (int k = 0; k < DB; k++) begin
      bus_b.ra = {5'd0, 5'(k)};
      #1;
      n_vec++;
      if (bus_b.rd[W-1:0] !== ref_b(0)) begin
        n_err++;
        $display("FAIL oor_entry%0d: rd0=%h, want %h", k, bus_b.rd[W-1:0], ref_b(0));
      end
    end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    bus_a.we = 2'b11; bus_a.wa = {5'd3, 5'd3}; bus_a.wd = {32'h22, 32'h11}; bus_a.ra = {5'd0, 5'd3};
    #1;
    n_vec++;
    if (bus_a.rd[W-1:0] !== 32'h22 || bus_a.rd[W-1:0] !== ref_a(0)) begin
      n_err++;
      $display("FAIL conflict_bypass: rd0=%h, want 22", bus_a.rd[W-1:0]);
    end
    tick();
    bus_a.we = 2'b00;
    @(negedge clk);
    n_vec++;
    if (bus_a.rd[W-1:0] !== 32'h22) begin
      n_err++;
      $display("FAIL conflict_stored: rd0=%h, want 22", bus_a.rd[W-1:0]);
    end
    bus_a.we = 2'b11; bus_a.wa = {5'd0, 5'd9}; bus_a.wd = {32'h66, 32'h55}; bus_a.ra = {5'd0, 5'd9};
    #1;
    n_vec++;
    if (bus_a.rd !== {32'h0, 32'h55}) begin
      n_err++;
      $display("FAIL bypass_drop: rd=%h, want 0000000000000055", bus_a.rd);
    end
    tick();
    bus_a.we = 2'b00;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus_a.we = 2'($urandom_range(0, 3));
      for (int i = 0; i < NWA; i++)
        bus_a.wa[i*AWA +: AWA] = 5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
      bus_a.wd = {$urandom(), $urandom()};
      for (int j = 0; j < NRA; j++)
        bus_a.ra[j*AWA +: AWA] = 5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
      bus_b.we = 1'($urandom_range(0, 1));
      bus_b.wa = 5'($urandom_range(0, 31));
      bus_b.wd = $urandom();
      for (int j = 0; j < NRB; j++) bus_b.ra[j*AWB +: AWB] = 5'($urandom_range(0, 31));
      #1;
      for (int j = 0; j < NRA; j++) begin
        n_vec++;
        if (bus_a.rd[j*W +: W] !== ref_a(j)) begin
          n_err++;
          $display("FAIL rand_a port%0d n=%0d: rd=%h, want %h", j, n, bus_a.rd[j*W +: W], ref_a(j));
        end
      end
      for (int j = 0; j < NRB; j++) begin
        n_vec++;
        if (bus_b.rd[j*W +: W] !== ref_b(j)) begin
          n_err++;
          $display("FAIL rand_b port%0d n=%0d: rd=%h, want %h", j, n, bus_b.rd[j*W +: W], ref_b(j));
        end
      end
      n_vec++;
      if (bus_a.clr_busy !== 1'b0 || bus_b.clr_busy !== 1'b0) begin
        n_err++;
        $display("FAIL rand_busy n=%0d: a=%b b=%b, want 0 0", n, bus_a.clr_busy, bus_b.clr_busy);
      end
      tick();
    end
    bus_a.we = '0;
    bus_b.we = '0;
  endtask

  task automatic test_scrub();
    int ba, da, dat;
    for (int k = 1; k < DA; k++) begin
      @(negedge clk);
      bus_a.we = 2'b01; bus_a.wa = {5'd0, 5'(k)}; bus_a.wd = {32'h0, 32'(k)};
      tick();
    end
    bus_a.we = '0;
    @(negedge clk);
    for (int k = 0; k < DA; k += 2) begin
      bus_a.ra = {5'(k + 1), 5'(k)};
      #1;
      n_vec++;
      if (bus_a.rd !== {32'(k + 1), (k == 0) ? 32'h0 : 32'(k)}) begin
        n_err++;
        $display("FAIL fill%0d: rd=%h, want index values", k, bus_a.rd);
      end
    end
    @(negedge clk);
    bus_a.clr_req = 1'b1;
    bus_a.we = 2'b01; bus_a.wa = {5'd0, 5'd4}; bus_a.wd = {32'h0, 32'hABCD};
    tick();
    bus_a.clr_req = 1'b0;
    bus_a.we = '0;
    ba = 0; da = 0; dat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= DA) begin
        bus_a.we = 2'b11;
        bus_a.wa = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
        bus_a.wd = {$urandom(), $urandom()};
        bus_a.ra = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
      end else begin
        bus_a.we = '0;
      end
      bus_a.clr_req = (c >= 5 && c <= 8);
      #1;
      if (bus_a.clr_busy === 1'b1) ba++;
      if (bus_a.clr_done === 1'b1) begin da++; if (dat == 0) dat = c; end
      if (c <= DA) begin
        n_vec++;
        if (bus_a.rd !== '0) begin
          n_err++;
          $display("FAIL scrub_rd c=%0d: rd=%h, want 0", c, bus_a.rd);
        end
      end
      tick();
    end
    bus_a.clr_req = 1'b0;
    n_vec++;
    if (ba != DA || da != 1 || dat != DA + 1) begin
      n_err++;
      $display("FAIL req_scrub: busy=%0d done=%0d at=%0d, want %0d 1 %0d", ba, da, dat, DA, DA + 1);
    end
    @(negedge clk);
    for (int k = 0; k < DA; k += 2) begin
      bus_a.ra = {5'(k + 1), 5'(k)};
      #1;
      n_vec++;
      if (bus_a.rd !== '0 || bus_a.rd !== {ref_a(1), ref_a(0)}) begin
        n_err++;
        $display("FAIL scrubbed%0d: rd=%h, want 0", k, bus_a.rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ba, da, dat, bb, db, dbt;
    int early;
    early = 0;
    @(negedge clk);
    bus_a.clr_req = 1'b1;
    tick();
    bus_a.clr_req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus_a.clr_done === 1'b1) early++;
      if (c < 10) tick();
    end
    reset = 1'b1;
    sl_a = DA; sl_b = DB; dn_a = 1'b0; dn_b = 1'b0;
    #1;
    n_vec++;
    if (bus_a.clr_busy !== 1'b1 || bus_a.clr_done !== 1'b0 || early != 0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b done=%b early_done=%0d, want 1 0 0",
               bus_a.clr_busy, bus_a.clr_done, early);
    end
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    count_scrub(ba, da, dat, bb, db, dbt);
    n_vec++;
    if (ba != DA || da != 1 || dat != DA + 1) begin
      n_err++;
      $display("FAIL mid_rescrub_a: busy=%0d done=%0d at=%0d, want %0d 1 %0d", ba, da, dat, DA, DA + 1);
    end
    n_vec++;
    if (bb != DB || db != 1 || dbt != DB + 1) begin
      n_err++;
      $display("FAIL mid_rescrub_b: busy=%0d done=%0d at=%0d, want %0d 1 %0d", bb, db, dbt, DB, DB + 1);
    end
    for (int k = 0; k < DB; k++) begin
      bus_b.ra = {5'd0, 5'(k)};
      bus_a.ra = {5'(k + 8), 5'(k)};
      #1;
      n_vec++;
      if (bus_b.rd[W-1:0] !== 32'h0 || bus_a.rd !== '0) begin
        n_err++;
        $display("FAIL mid_zero%0d: a=%h b=%h, want 0", k, bus_a.rd, bus_b.rd[W-1:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.we = '0; bus_a.wa = '0; bus_a.wd = '0; bus_a.ra = '0; bus_a.clr_req = 1'b0;
    bus_b.we = '0; bus_b.wa = '0; bus_b.wd = '0; bus_b.ra = '0; bus_b.clr_req = 1'b0;
    test_reset();
    test_basic();
    test_conflict();
    test_random();
    test_scrub();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
